fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, width of FIFO word and stream data.
REQ-002 SHALL have parameter BURST_LEN, default 4, words per burst; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to read one burst.
REQ-006 SHALL have port fifo_data  input  DATA_WIDTH  FIFO head word, combinational (first-word-fall-through).
REQ-007 SHALL have port fifo_empty  input  1  FIFO holds no words.
REQ-008 SHALL have port read_enable  output  1  pop request to FIFO, consumed on the same edge.
REQ-009 SHALL have port m_valid  output  1  stream word valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts word.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-012 SHALL have port m_last  output  1  marks final word of a burst.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port burst_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN.
REQ-016 IDLE->RUN on start; start while busy SHALL be ignored, not queued.
REQ-017 SHALL drive read_enable = (state==RUN) && !fifo_empty && (!m_valid || m_ready) && (remaining>0), combinationally.
REQ-018 A pop SHALL load fifo_data into m_data on the same edge and set m_valid.
REQ-019 Stream handshake: a transfer occurs on an edge with m_valid && m_ready; m_valid SHALL stay high and m_data/m_last SHALL stay stable until transferred.
REQ-020 m_valid SHALL clear on transfer when no pop occurs in that cycle; pop and transfer in one cycle SHALL keep m_valid high (1 word/cycle throughput).
REQ-021 An 8-bit remaining counter SHALL load BURST_LEN on IDLE->RUN and decrement by 1 per pop.
REQ-022 The pop that takes remaining from 1 to 0 SHALL set m_last with that word and move RUN->DRAIN.
REQ-023 DRAIN->IDLE on the edge transferring the m_last word; burst_done SHALL be high for exactly the following cycle.
REQ-024 fifo_empty in RUN SHALL stall pops without error; the burst resumes when data arrives.
REQ-025 m_ready low SHALL stall pops; no word is lost or duplicated.
REQ-026 Latency: start sampled at edge N -> first pop in cycle after N if FIFO non-empty -> m_valid high after edge N+1.
REQ-027 BURST_LEN=1: the first pop SHALL carry m_last and enter DRAIN directly.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, remaining 0, m_valid 0, m_last 0, m_data 0, burst_done 0.
REQ-029 read_enable and busy SHALL be 0 while in reset.
REQ-030 Reset mid-burst SHALL abandon the burst; the held word is discarded and no burst_done is issued.

Structure
REQ-031 State enum type and the counter width constant SHALL live in a shared package fifo_pkg.
REQ-032 The output stage SHALL be a sub-module stream_out_reg (data/last/valid register with hold-on-stall); FSM and counter SHALL stay in the top.

Verification
REQ-033 FIFO preloaded 1,2,3,4; m_ready=1; start -> read_enable high 4 consecutive cycles, m_data 1,2,3,4, m_last only on 4, burst_done one cycle after.
REQ-034 Same preload; m_ready low for 3 cycles after first m_valid -> m_data holds 1, read_enable low, final sequence 1,2,3,4 with no duplicates.
REQ-035 FIFO holds 2 words, 2 more written 5 cycles later -> read_enable never high when fifo_empty, burst completes with 4 words, m_last on 4th.
REQ-036 start pulsed again while busy -> ignored; exactly BURST_LEN words and one burst_done per accepted start.
REQ-037 rst_n asserted after 2nd word accepted -> m_valid, busy, read_enable 0 immediately; no burst_done; next start reads from current FIFO head.
REQ-038 BURST_LEN=1 build, FIFO holds 9 -> single word 9 with m_last=1, burst_done pulse, return to IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-to-stream burst reader.
package fifo_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output register for a valid/ready stream.
// Holds data/last stable while the consumer stalls.
module stream_out_reg #(
   parameter int unsigned DATA_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   input  logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  last
);

   // A load wins over a transfer so pop+transfer keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (valid && ready) begin
         valid <= 1'b0;
         last  <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads fixed-length bursts from a first-word-fall-through FIFO
// and presents them on a valid/ready stream with an end-of-burst marker.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 6,
   parameter int unsigned BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  read_enable,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  burst_done
);

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic             pop;
   logic             last_pop;
   logic             xfer;

   // Pop only when the output slot is free or being emptied this cycle.
   assign pop = (state == RUN) && !fifo_empty && (!m_valid || m_ready) &&
                (remaining != '0);
   assign last_pop    = pop && (remaining == CNT_W'(1));
   assign xfer        = m_valid && m_ready;
   assign read_enable = pop;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  remaining <= CNT_W'(BURST_LEN);
               end
            end
            RUN: begin
               if (pop) begin
                  remaining <= remaining - CNT_W'(1);
                  if (last_pop) state <= DRAIN;
               end
            end
            DRAIN: begin
               // Only the last word can be held here, so any transfer ends the burst.
               if (xfer) begin
                  state      <= IDLE;
                  burst_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   stream_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (pop),
      .load_data (fifo_data),
      .load_last (last_pop),
      .ready     (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .last      (m_last)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: FIFO model, burst-level reference
// model, and an independent stream monitor; plus a BURST_LEN=1 instance.
module tb_fifo_stream_reader;

   localparam int unsigned DW = 6;
   localparam int unsigned BL = 4;

   typedef struct {
      int idx;
      bit last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_empty = 1'b1;
   logic          read_enable, m_valid, m_last, busy, burst_done;
   logic [DW-1:0] m_data;

   logic          start1 = 1'b0;
   logic          m_ready1 = 1'b0;
   logic          has1 = 1'b0;
   logic          fifo_empty1;
   logic [DW-1:0] fifo_data1;
   logic          read_enable1, m_valid1, m_last1, busy1, burst_done1;
   logic [DW-1:0] m_data1;

   int            checks = 0;
   int            errors = 0;

   logic [DW-1:0] wr_hist[$];
   logic [DW-1:0] fifo_q[$];
   exp_t          sb[$];

   int            pop_count = 0;
   int            next_rd = 0;
   int            starts_issued = 0;
   int            pops_seen = 0;
   int            starts_applied = 0;
   int            xfer_count = 0;
   bit            model_busy = 1'b0;
   bit            done_exp = 1'b0;

   always #5 clk = ~clk;

   assign fifo_empty1 = !has1;
   assign fifo_data1  = DW'(9);

   fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fifo_data(fifo_data),
      .fifo_empty(fifo_empty), .read_enable(read_enable), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
      .burst_done(burst_done)
   );

   fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .fifo_data(fifo_data1),
      .fifo_empty(fifo_empty1), .read_enable(read_enable1), .m_valid(m_valid1),
      .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1), .busy(busy1),
      .burst_done(burst_done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fifo_sync();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   task automatic push(input logic [DW-1:0] v);
      fifo_q.push_back(v);
      wr_hist.push_back(v);
      fifo_sync();
   endtask

   // Advance to the next falling edge and retire the pops the DUT made.
   task automatic tick();
      @(negedge clk);
      start  = 1'b0;
      start1 = 1'b0;
      while (pop_count < pops_seen) begin
         void'(fifo_q.pop_front());
         pop_count++;
      end
      fifo_sync();
   endtask

   // A start is accepted only when the model says the reader is idle.
   task automatic issue_start();
      start = 1'b1;
      if (!model_busy && starts_issued == starts_applied) begin
         for (int i = 0; i < int'(BL); i++) begin
            exp_t e;
            e.idx  = next_rd + i;
            e.last = (i == int'(BL) - 1);
            sb.push_back(e);
         end
         next_rd += int'(BL);
         starts_issued++;
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < max_cycles && !idle; i++) begin
         tick();
         idle = !model_busy && (starts_issued == starts_applied) && (sb.size() == 0);
      end
      tick();
      check("idle_reached", idle, 1);
   endtask

   task automatic wait_xfers(input int target, input int max_cycles);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < max_cycles && !hit; i++) begin
         tick();
         hit = (xfer_count >= target);
      end
      check("xfer_reached", hit, 1);
   endtask

   // Monitor: samples just after each falling edge, predicts the next rising edge.
   initial begin
      bit            hold_valid;
      logic [DW-1:0] hold_data;
      logic          hold_last;
      exp_t          e;
      hold_valid = 1'b0;
      hold_data  = '0;
      hold_last  = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            check("rst_m_last", m_last, 0);
            check("rst_read_enable", read_enable, 0);
            check("rst_busy", busy, 0);
            check("rst_burst_done", burst_done, 0);
            hold_valid     = 1'b0;
            done_exp       = 1'b0;
            model_busy     = 1'b0;
            starts_applied = starts_issued;
            sb.delete();
         end else begin
            check("busy", busy, model_busy);
            check("burst_done", burst_done, done_exp);
            done_exp = 1'b0;
            if (read_enable) begin
               check("re_when_empty", fifo_empty, 0);
               pops_seen++;
            end
            if (hold_valid) begin
               check("hold_valid", m_valid, 1);
               check("hold_data", m_data, hold_data);
               check("hold_last", m_last, hold_last);
            end
            if (m_valid && m_ready) begin
               xfer_count++;
               check("sb_pending", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("word_written", e.idx < wr_hist.size(), 1);
                  if (e.idx < wr_hist.size()) check("m_data", m_data, wr_hist[e.idx]);
                  check("m_last", m_last, e.last);
                  if (e.last) begin
                     model_busy = 1'b0;
                     done_exp   = 1'b1;
                  end
               end
            end
            hold_valid = m_valid && !m_ready;
            hold_data  = m_data;
            hold_last  = m_last;
            if (starts_applied != starts_issued) begin
               model_busy     = 1'b1;
               starts_applied = starts_issued;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Back-to-back burst with an always-ready consumer.
      push(1); push(2); push(3); push(4);
      m_ready = 1'b1;
      issue_start();
      for (int k = 0; k < 4; k++) begin
         tick();
         #2 check("re_back_to_back", read_enable, 1);
      end
      tick();
      #2 check("re_after_burst", read_enable, 0);
      wait_idle(50);

      // Consumer stalls for three cycles after the first word.
      push(1); push(2); push(3); push(4);
      m_ready = 1'b0;
      issue_start();
      tick();
      #2 check("re_first_pop", read_enable, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         #2;
         check("stall_re", read_enable, 0);
         check("stall_valid", m_valid, 1);
         check("stall_data", m_data, 1);
      end
      tick();
      m_ready = 1'b1;
      wait_idle(50);

      // FIFO runs dry mid-burst and refills later.
      push(10); push(11);
      issue_start();
      for (int k = 0; k < 5; k++) tick();
      push(12); push(13);
      wait_idle(50);

      // Extra starts while busy are dropped.
      push(40); push(41); push(42); push(43);
      issue_start();
      tick();
      tick();
      issue_start();
      tick();
      tick();
      tick();
      issue_start();
      wait_idle(50);

      // Reset in the middle of a burst.
      push(20); push(21); push(22); push(23);
      issue_start();
      base = xfer_count;
      wait_xfers(base + 2, 50);
      rst_n = 1'b0;
      #3;
      next_rd       = pop_count;
      starts_issued = starts_applied;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      push(30); push(31); push(32); push(33);
      issue_start();
      wait_idle(50);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         tick();
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) push(DW'($urandom_range(0, 63)));
         if ($urandom_range(0, 11) == 0) issue_start();
      end
      tick();
      m_ready = 1'b1;
      for (int k = 0; k < int'(BL); k++) push(DW'($urandom_range(0, 63)));
      wait_idle(200);

      // Single-word burst build.
      has1     = 1'b1;
      m_ready1 = 1'b1;
      start1   = 1'b1;
      tick();
      #2 check("bl1_re", read_enable1, 1);
      tick();
      has1 = 1'b0;
      #2;
      check("bl1_valid", m_valid1, 1);
      check("bl1_data", m_data1, 9);
      check("bl1_last", m_last1, 1);
      check("bl1_busy", busy1, 1);
      check("bl1_re_done", read_enable1, 0);
      tick();
      #2;
      check("bl1_done", burst_done1, 1);
      check("bl1_idle", busy1, 0);
      check("bl1_valid_clr", m_valid1, 0);
      tick();
      #2 check("bl1_done_pulse", burst_done1, 0);

      tick();
      check("sb_empty_end", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
